branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch unit for the pipelined RV32I core: resolves branches/jumps in execute and predicts them in fetch with a direct-mapped branch target buffer of 2-bit saturating counters. Fetch reads a prediction combinationally; execute resolves, flags mispredictions, issues a registered redirect and trains the table. Supports the same branch modes as the single-cycle core's branch logic, with sign-correct offset arithmetic and performance counters.

## Interface
- XLEN, 32: datapath width; PCs are word addresses of XLEN-2 bits
- BTB_ENTRIES, 64: table depth, power of two ≥ 2; IDX_W = log2(BTB_ENTRIES)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_pc  in  XLEN-2  word PC being fetched
- pred_taken  out  1  prediction for fetch_pc
- pred_target  out  XLEN-2  predicted word target (0 when pred_taken=0)
- res_valid  in  1  execute stage holds a valid instruction
- res_pc  in  XLEN-2  word PC of that instruction
- res_pred_taken  in  1  prediction carried down the pipe
- res_pred_target  in  XLEN-2  predicted target carried down the pipe
- bra_mode  in  2  00 none, 01 JMP (pc+imm), 10 CMP (conditional), 11 ALU (indirect)
- cmp_src  in  2  00 alu_z, 10 src_alu[XLEN-1], 11 alu_c, 01 constant 0
- cmp_inv  in  1  invert condition
- src_alu, src_imm  in  XLEN  ALU result, byte immediate
- alu_z, alu_c  in  1  ALU flags
- jmp_enable  out  1  actual taken (combinational, gated by res_valid)
- jmp_addr  out  XLEN-2  actual target (combinational)
- redirect_valid  out  1  registered mispredict/flush request
- redirect_pc  out  XLEN-2  registered correct next PC
- perf_branches, perf_mispredicts  out  32  event counters

## Operation
- Entry: valid, uncond, tag (XLEN-2-IDX_W bits), ctr[1:0], target. Index = pc[IDX_W-1:0], tag = pc[XLEN-3:IDX_W].
- Lookup: hit = valid && tag match; pred_taken = hit && (uncond || ctr[1]); pred_target = target when pred_taken.
- Resolution: cond = selected source ^ cmp_inv. JMP: taken, target = res_pc + (src_imm >>> 2) (arithmetic shift, sum mod 2^(XLEN-2)). CMP: taken = cond, same target. ALU: taken, target = src_alu[XLEN-1:2]. none: not taken, jmp_addr = res_pc+1.
- mispredict = res_valid && (taken != res_pred_taken || (taken && jmp_addr != res_pred_target)).
- Training (only when res_valid, index/tag from res_pc):
  - JMP: write valid=1, uncond=1, ctr=11, tag, target.
  - CMP hit: ctr saturating +1 if taken, −1 if not (bounds 00/11); if taken also rewrite target.
  - CMP miss & taken: allocate valid=1, uncond=0, ctr=10, tag, target. CMP miss & not taken: no write.
  - ALU: no allocation; hit entry invalidated (indirect never predicted).
  - none with hit: invalidate entry (alias cleanup).
- perf_branches += 1 when res_valid && bra_mode≠00; perf_mispredicts += 1 on mispredict; both wrap at 2^32.

## Timing
- Reset (async, immediate): all valid=0, ctr=01, pred_taken=0, pred_target=0, redirect_valid=0, redirect_pc=0, perf counters=0. Reset mid-training discards the pending write.
- Lookup and resolution outputs: 0-cycle combinational.
- Table write, redirect and counters update on the rising edge after resolution; redirect_valid is a 1-cycle pulse per mispredict; redirect_pc = taken ? jmp_addr : res_pc+1.
- Back-to-back mispredicts produce back-to-back pulses.
- Same-cycle lookup and write to one index: lookup returns pre-write contents (no bypass).
- res_valid=0: jmp_enable=0, no write, no count, redirect_valid=0 next cycle.

## Test plan
- Reset, fetch_pc=0x10 -> pred_taken=0, pred_target=0, all counters 0.
- JMP res_pc=0x10, src_imm=-8, res_pred_taken=0 -> jmp_addr=0x0E, jmp_enable=1; next cycle redirect_valid=1, redirect_pc=0x0E, perf_mispredicts=1; fetch_pc=0x10 then predicts taken 0x0E.
- CMP at 0x20, cmp_src=00, alu_z=1, imm=+16, four times taken then three not taken -> ctr 10,11,11,11,10,01,00; predictions taken until ctr falls to 01.
- Alias: BTB_ENTRIES=64, train JMP at 0x05, resolve bra_mode=00 at 0x45 with res_pred_taken=1 -> mispredict, redirect_pc=0x46, entry 5 tag-mismatched so untouched; then none at 0x05 invalidates it.
- ALU mode, src_alu=0x0000_0104 -> jmp_addr=0x41, no allocation, mispredict if res_pred_taken=0.
- Assert rst_n mid-sequence with res_valid=1 -> outputs and counters zero immediately, no table write.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch unit for the pipelined RV32I core.
// Fetch side: direct-mapped BTB lookup with 2-bit saturating counters.
// Execute side: resolves the branch, flags mispredictions, raises a
// registered redirect, trains the BTB and counts branch events.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-3:0]   fetch_pc,
    output logic              pred_taken,
    output logic [XLEN-3:0]   pred_target,
    input  logic              res_valid,
    input  logic [XLEN-3:0]   res_pc,
    input  logic              res_pred_taken,
    input  logic [XLEN-3:0]   res_pred_target,
    input  logic [1:0]        bra_mode,
    input  logic [1:0]        cmp_src,
    input  logic              cmp_inv,
    input  logic [XLEN-1:0]   src_alu,
    input  logic [XLEN-1:0]   src_imm,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic              jmp_enable,
    output logic [XLEN-3:0]   jmp_addr,
    output logic              redirect_valid,
    output logic [XLEN-3:0]   redirect_pc,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    localparam int PW    = XLEN - 2;
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PW - IDX_W;

    localparam logic [1:0] BRA_NONE = 2'b00;
    localparam logic [1:0] BRA_JMP  = 2'b01;
    localparam logic [1:0] BRA_CMP  = 2'b10;
    localparam logic [1:0] BRA_ALU  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic             uncond;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic [PW-1:0]    target;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, uncond: 1'b0, tag: '0, ctr: 2'b01, target: '0};

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];

    logic          redirect_valid_q, redirect_valid_d;
    logic [PW-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]   perf_branches_q, perf_branches_d;
    logic [31:0]   perf_mispredicts_q, perf_mispredicts_d;

    logic [IDX_W-1:0] f_idx;
    logic             f_hit;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             cond_src;
    logic             cond;
    logic             taken_raw;
    logic [PW-1:0]    seq_pc;
    logic [PW-1:0]    rel_target;
    logic             mispredict;
    logic [PW-1:0]    correct_pc;
    btb_entry_t       upd;
    logic             unused_low_bits;

    // The low two byte-address bits never matter for word targets.
    assign unused_low_bits = ^{src_imm[1:0], src_alu[1:0]};

    assign f_idx = fetch_pc[IDX_W-1:0];
    assign r_idx = res_pc[IDX_W-1:0];
    assign r_tag = res_pc[PW-1:IDX_W];

    // Fetch lookup reads the registered table only, so a same-cycle write is not bypassed.
    always_comb begin
        f_hit       = btb_q[f_idx].valid && (btb_q[f_idx].tag == fetch_pc[PW-1:IDX_W]);
        pred_taken  = f_hit && (btb_q[f_idx].uncond || btb_q[f_idx].ctr[1]);
        pred_target = pred_taken ? btb_q[f_idx].target : '0;
    end

    // Resolve the branch in execute: condition, actual direction and target, mispredict.
    always_comb begin
        cond_src = 1'b0;
        case (cmp_src)
            2'b00:   cond_src = alu_z;
            2'b10:   cond_src = src_alu[XLEN-1];
            2'b11:   cond_src = alu_c;
            default: cond_src = 1'b0;
        endcase
        cond       = cond_src ^ cmp_inv;
        seq_pc     = res_pc + PW'(1);
        // Arithmetic shift by two then truncation to PW bits is just the upper slice.
        rel_target = res_pc + src_imm[XLEN-1:2];
        taken_raw  = 1'b0;
        jmp_addr   = seq_pc;
        case (bra_mode)
            BRA_NONE: begin
                taken_raw = 1'b0;
                jmp_addr  = seq_pc;
            end
            BRA_JMP: begin
                taken_raw = 1'b1;
                jmp_addr  = rel_target;
            end
            BRA_CMP: begin
                taken_raw = cond;
                jmp_addr  = rel_target;
            end
            BRA_ALU: begin
                taken_raw = 1'b1;
                jmp_addr  = src_alu[XLEN-1:2];
            end
        endcase
        jmp_enable = res_valid && taken_raw;
        mispredict = res_valid && ((jmp_enable != res_pred_taken) ||
                                   (jmp_enable && (jmp_addr != res_pred_target)));
        correct_pc = jmp_enable ? jmp_addr : seq_pc;
    end

    // Compute the trained table contents; only the resolved index can change.
    always_comb begin
        btb_d = btb_q;
        upd   = btb_q[r_idx];
        r_hit = btb_q[r_idx].valid && (btb_q[r_idx].tag == r_tag);
        if (res_valid) begin
            case (bra_mode)
                BRA_JMP: begin
                    upd.valid  = 1'b1;
                    upd.uncond = 1'b1;
                    upd.ctr    = 2'b11;
                    upd.tag    = r_tag;
                    upd.target = jmp_addr;
                end
                BRA_CMP: begin
                    if (r_hit) begin
                        if (taken_raw) begin
                            if (upd.ctr != 2'b11) upd.ctr = upd.ctr + 2'b01;
                            upd.target = jmp_addr;
                        end else begin
                            if (upd.ctr != 2'b00) upd.ctr = upd.ctr - 2'b01;
                        end
                    end else if (taken_raw) begin
                        upd.valid  = 1'b1;
                        upd.uncond = 1'b0;
                        upd.ctr    = 2'b10;
                        upd.tag    = r_tag;
                        upd.target = jmp_addr;
                    end
                end
                default: begin
                    // Indirect jumps are never predicted and plain instructions
                    // that alias onto a live entry clear it.
                    if (r_hit) upd.valid = 1'b0;
                end
            endcase
        end
        btb_d[r_idx] = upd;
    end

    // Next-state for redirect and event counters.
    always_comb begin
        redirect_valid_d   = mispredict;
        redirect_pc_d      = mispredict ? correct_pc : redirect_pc_q;
        perf_branches_d    = perf_branches_q + 32'((res_valid && (bra_mode != BRA_NONE)) ? 1 : 0);
        perf_mispredicts_d = perf_mispredicts_q + 32'(mispredict ? 1 : 0);
    end

    // State registers; reset drops any training write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= RESET_ENTRY;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= btb_d[i];
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit: each vector drives one execute
// resolution plus a fetch lookup and checks combinational and next-edge results.
module tb_branch_predict_unit;

    localparam int XLEN = 32;
    localparam int PW   = XLEN - 2;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] JMP  = 2'b01;
    localparam logic [1:0] CMP  = 2'b10;
    localparam logic [1:0] ALU  = 2'b11;

    logic            clk;
    logic            rst_n;
    logic [PW-1:0]   fetch_pc;
    logic            pred_taken;
    logic [PW-1:0]   pred_target;
    logic            res_valid;
    logic [PW-1:0]   res_pc;
    logic            res_pred_taken;
    logic [PW-1:0]   res_pred_target;
    logic [1:0]      bra_mode;
    logic [1:0]      cmp_src;
    logic            cmp_inv;
    logic [XLEN-1:0] src_alu;
    logic [XLEN-1:0] src_imm;
    logic            alu_z;
    logic            alu_c;
    logic            jmp_enable;
    logic [PW-1:0]   jmp_addr;
    logic            redirect_valid;
    logic [PW-1:0]   redirect_pc;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    int total;
    int bad;
    int exp_branches;
    int exp_mis;

    typedef struct {
        logic          rv;
        logic [PW-1:0] rpc;
        logic          rpt;
        logic [PW-1:0] rptg;
        logic [1:0]    mode;
        logic [1:0]    csrc;
        logic          inv;
        logic [31:0]   alu;
        logic [31:0]   imm;
        logic          z;
        logic          c;
        logic [PW-1:0] fpc;
        logic          e_pt;
        logic [PW-1:0] e_ptg;
        logic          e_en;
        logic [PW-1:0] e_addr;
        logic          e_mis;
        logic [PW-1:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    branch_predict_unit #(.XLEN(XLEN), .BTB_ENTRIES(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .bra_mode        (bra_mode),
        .cmp_src         (cmp_src),
        .cmp_inv         (cmp_inv),
        .src_alu         (src_alu),
        .src_imm         (src_imm),
        .alu_z           (alu_z),
        .alu_c           (alu_c),
        .jmp_enable      (jmp_enable),
        .jmp_addr        (jmp_addr),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic rv, logic [PW-1:0] rpc, logic rpt, logic [PW-1:0] rptg,
                                logic [1:0] mode, logic [1:0] csrc, logic inv, logic [31:0] alu,
                                logic [31:0] imm, logic z, logic c, logic [PW-1:0] fpc,
                                logic e_pt, logic [PW-1:0] e_ptg, logic e_en, logic [PW-1:0] e_addr,
                                logic e_mis, logic [PW-1:0] e_rpc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rpt = rpt; v.rptg = rptg; v.mode = mode; v.csrc = csrc;
        v.inv = inv; v.alu = alu; v.imm = imm; v.z = z; v.c = c; v.fpc = fpc;
        v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_en = e_en; v.e_addr = e_addr;
        v.e_mis = e_mis; v.e_rpc = e_rpc;
        return v;
    endfunction

    // Idle execute stage (no instruction) while only the fetch lookup is observed.
    function automatic vec_t idle(logic [PW-1:0] fpc, logic e_pt, logic [PW-1:0] e_ptg);
        return mk(1'b0, '0, 1'b0, '0, NONE, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, fpc,
                  e_pt, e_ptg, 1'b0, PW'(1), 1'b0, '0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        @(negedge clk);
        res_valid       = v.rv;
        res_pc          = v.rpc;
        res_pred_taken  = v.rpt;
        res_pred_target = v.rptg;
        bra_mode        = v.mode;
        cmp_src         = v.csrc;
        cmp_inv         = v.inv;
        src_alu         = v.alu;
        src_imm         = v.imm;
        alu_z           = v.z;
        alu_c           = v.c;
        fetch_pc        = v.fpc;
        #1;
        checkOutput($sformatf("v%0d pred_taken", n), 32'(pred_taken), 32'(v.e_pt));
        checkOutput($sformatf("v%0d pred_target", n), 32'(pred_target), 32'(v.e_ptg));
        checkOutput($sformatf("v%0d jmp_enable", n), 32'(jmp_enable), 32'(v.e_en));
        checkOutput($sformatf("v%0d jmp_addr", n), 32'(jmp_addr), 32'(v.e_addr));
        if (v.rv && v.mode != NONE) exp_branches++;
        if (v.e_mis) exp_mis++;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d redirect_valid", n), 32'(redirect_valid), 32'(v.e_mis));
        if (v.e_mis)
            checkOutput($sformatf("v%0d redirect_pc", n), 32'(redirect_pc), 32'(v.e_rpc));
        checkOutput($sformatf("v%0d perf_branches", n), perf_branches, 32'(exp_branches));
        checkOutput($sformatf("v%0d perf_mispredicts", n), perf_mispredicts, 32'(exp_mis));
    endtask

    // Main sequence: reset, vector table, then asynchronous reset during a resolution.
    initial begin
        total = 0; bad = 0; exp_branches = 0; exp_mis = 0;
        rst_n = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_pred_taken = 1'b0; res_pred_target = '0;
        bra_mode = NONE; cmp_src = 2'b00; cmp_inv = 1'b0; src_alu = '0; src_imm = '0;
        alu_z = 1'b0; alu_c = 1'b0; fetch_pc = PW'('h10);

        // JMP with negative offset, then its prediction.
        vecs.push_back(mk(1, 'h10, 0, 0, JMP, 0, 0, 0, 32'hFFFF_FFF8, 0, 0, 'h10, 0, 0, 1, 'h0E, 1, 'h0E));
        vecs.push_back(idle('h10, 1, 'h0E));
        // CMP training: four taken, three not taken.
        vecs.push_back(mk(1, 'h20, 0, 0,     CMP, 0, 0, 0, 16, 1, 0, 'h20, 0, 0,     1, 'h24, 1, 'h24));
        vecs.push_back(mk(1, 'h20, 1, 'h24,  CMP, 0, 0, 0, 16, 1, 0, 'h20, 1, 'h24,  1, 'h24, 0, 0));
        vecs.push_back(mk(1, 'h20, 1, 'h24,  CMP, 0, 0, 0, 16, 1, 0, 'h20, 1, 'h24,  1, 'h24, 0, 0));
        vecs.push_back(mk(1, 'h20, 1, 'h24,  CMP, 0, 0, 0, 16, 1, 0, 'h20, 1, 'h24,  1, 'h24, 0, 0));
        vecs.push_back(mk(1, 'h20, 1, 'h24,  CMP, 0, 0, 0, 16, 0, 0, 'h20, 1, 'h24,  0, 'h24, 1, 'h21));
        vecs.push_back(mk(1, 'h20, 1, 'h24,  CMP, 0, 0, 0, 16, 0, 0, 'h20, 1, 'h24,  0, 'h24, 1, 'h21));
        vecs.push_back(mk(1, 'h20, 0, 0,     CMP, 0, 0, 0, 16, 0, 0, 'h20, 0, 0,     0, 'h24, 0, 0));
        vecs.push_back(idle('h20, 0, 0));
        // Alias on index 5: 0x45 leaves entry alone, plain instruction at 0x05 clears it.
        vecs.push_back(mk(1, 'h05, 0, 0,     JMP,  0, 0, 0, 4, 0, 0, 'h05, 0, 0,     1, 'h06, 1, 'h06));
        vecs.push_back(mk(1, 'h45, 1, 'h06,  NONE, 0, 0, 0, 0, 0, 0, 'h05, 1, 'h06,  0, 'h46, 1, 'h46));
        vecs.push_back(mk(1, 'h05, 1, 'h06,  NONE, 0, 0, 0, 0, 0, 0, 'h05, 1, 'h06,  0, 'h06, 1, 'h06));
        vecs.push_back(idle('h05, 0, 0));
        // Indirect: no allocation, and a hit entry gets invalidated.
        vecs.push_back(mk(1, 'h30, 0, 0,     ALU, 0, 0, 32'h104, 0, 0, 0, 'h30, 0, 0,     1, 'h41, 1, 'h41));
        vecs.push_back(idle('h30, 0, 0));
        vecs.push_back(mk(1, 'h31, 0, 0,     JMP, 0, 0, 0,       0, 0, 0, 'h31, 0, 0,     1, 'h31, 1, 'h31));
        vecs.push_back(mk(1, 'h31, 1, 'h31,  ALU, 0, 0, 32'h200, 0, 0, 0, 'h31, 1, 'h31,  1, 'h80, 1, 'h80));
        vecs.push_back(idle('h31, 0, 0));
        // Condition source selection and inversion.
        vecs.push_back(mk(1, 'h50, 0, 0, CMP, 2'b10, 0, 32'h8000_0000, 8,           0, 0, 'h50, 0, 0, 1, 'h52, 1, 'h52));
        vecs.push_back(mk(1, 'h60, 0, 0, CMP, 2'b11, 0, 0,             8,           1, 0, 'h60, 0, 0, 0, 'h62, 0, 0));
        vecs.push_back(mk(1, 'h60, 0, 0, CMP, 2'b01, 1, 0,             32'hFFFF_FFFC, 1, 0, 'h60, 0, 0, 1, 'h5F, 1, 'h5F));
        vecs.push_back(idle('h60, 1, 'h5F));
        // Target wraps modulo 2^30 below zero; fetch checks the 0x50 allocation.
        vecs.push_back(mk(1, 'h00, 0, 0, JMP, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 'h50, 1, 'h52, 1, 'h3FFF_FFFF, 1, 'h3FFF_FFFF));

        #1;
        checkOutput("reset pred_taken", 32'(pred_taken), 0);
        checkOutput("reset pred_target", 32'(pred_target), 0);
        checkOutput("reset redirect_valid", 32'(redirect_valid), 0);
        checkOutput("reset redirect_pc", 32'(redirect_pc), 0);
        checkOutput("reset perf_branches", perf_branches, 0);
        checkOutput("reset perf_mispredicts", perf_mispredicts, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Asynchronous reset while a JMP is being resolved.
        @(negedge clk);
        res_valid = 1'b1; res_pc = PW'('h70); res_pred_taken = 1'b0; res_pred_target = '0;
        bra_mode = JMP; src_imm = 32'd8; fetch_pc = PW'('h50);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async redirect_valid", 32'(redirect_valid), 0);
        checkOutput("async redirect_pc", 32'(redirect_pc), 0);
        checkOutput("async perf_branches", perf_branches, 0);
        checkOutput("async perf_mispredicts", perf_mispredicts, 0);
        checkOutput("async pred_taken", 32'(pred_taken), 0);
        checkOutput("async pred_target", 32'(pred_target), 0);
        @(posedge clk);
        #1;
        checkOutput("held redirect_valid", 32'(redirect_valid), 0);
        checkOutput("held perf_branches", perf_branches, 0);
        @(negedge clk);
        rst_n = 1'b1; res_valid = 1'b0; bra_mode = NONE; fetch_pc = PW'('h70);
        #1;
        checkOutput("post-reset no write pred_taken", 32'(pred_taken), 0);
        checkOutput("post-reset idle jmp_enable", 32'(jmp_enable), 0);
        @(posedge clk);
        #1;
        checkOutput("post-reset redirect_valid", 32'(redirect_valid), 0);
        checkOutput("post-reset perf_branches", perf_branches, 0);
        checkOutput("post-reset perf_mispredicts", perf_mispredicts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
